riscv_axi_sram_subordinate: RTL
===============================

Name: riscv_axi_sram_subordinate

Overview:
- Single-beat AXI4 subordinate backed by a word-addressed SRAM array.
- Sits at the far end of the axi4_pkg link from the RISC-V AXI request driver and serves as the instruction/data memory model and on-chip scratchpad.
- Accepts AR, AW and W independently and returns R and B carrying the request ID.
- Supports several outstanding reads so the driver's ID-tagged pending queue can be exercised at full throughput.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
DEPTH_WORDS, 1024, number of 32-bit words; power of two
RD_Q_DEPTH, 4, read response FIFO entries (outstanding reads); power of two, at least 2

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
AXI_AW_M  input  axi4_pkg::aw_m  write address from manager (AWVALID, AWID[3:0], AWADDR[31:0])
AXI_W_M  input  axi4_pkg::w_m  write data (WVALID, WDATA[31:0], WSTRB[3:0])
AXI_B_M  input  axi4_pkg::b_m  write response ready (BREADY)
AXI_AR_M  input  axi4_pkg::ar_m  read address (ARVALID, ARID[3:0], ARADDR[31:0])
AXI_R_M  input  axi4_pkg::r_m  read data ready (RREADY)
AXI_AW_S  output  axi4_pkg::aw_s  AWREADY
AXI_W_S  output  axi4_pkg::w_s  WREADY
AXI_B_S  output  axi4_pkg::b_s  BVALID, BID[3:0], BRESP[1:0]
AXI_AR_S  output  axi4_pkg::ar_s  ARREADY
AXI_R_S  output  axi4_pkg::r_s  RVALID, RID[3:0], RDATA[31:0], RRESP[1:0], RLAST

Behaviour:
- Reset, while reset is low: all *_S fields are 0. Read FIFO is emptied, AW/W holding registers are cleared, and BVALID is cleared.
- SRAM contents are not reset.
- A reset asserted mid-transaction drops every accepted-but-unanswered request. No R or B is issued for it.
- All output struct fields not listed in Ports are driven 0.
- Address decode:
  - OKAY (2'b00) when BASE_ADDR <= ADDR < BASE_ADDR + 4*DEPTH_WORDS; word index = (ADDR - BASE_ADDR) >> 2, and ADDR[1:0] is ignored.
  - Otherwise DECERR (2'b11): a read returns RDATA = 0 and a write modifies nothing.
- Burst fields (LEN, SIZE, BURST) are ignored. Every transaction is one 32-bit beat and RLAST = 1 whenever RVALID = 1.
- Read path:
  - ARREADY = (FIFO count < RD_Q_DEPTH), a function of registered state only. There is no combinational RREADY-to-ARREADY path.
  - On ARVALID & ARREADY in cycle N, the SRAM word is read and {ARID, data, resp} is pushed at the end of N. RVALID = 1 from cycle N+1.
  - RVALID = FIFO non-empty, with R fields taken from the head. Pop on RVALID & RREADY.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Responses leave in acceptance order. Back-to-back reads sustain one per cycle while RREADY = 1.
  - R outputs remain stable while RVALID & ~RREADY.
- Write path:
  - AWREADY = ~aw_held and WREADY = ~w_held. AW and W may arrive in either order or in the same cycle.
  - Commit fires when aw_held & w_held & (~BVALID | BREADY). On commit:
    - bytes with WSTRB[i] = 1 are written to SRAM (OKAY only);
    - BID = held AWID and BRESP is loaded;
    - BVALID is set next cycle;
    - both held flags are cleared.
  - Latency: with both handshakes complete by cycle N, commit occurs at the end of N+1 and BVALID = 1 in N+2.
  - BVALID stays high until BREADY, and B fields remain stable while waiting.
  - A commit in the same cycle as a B handshake is allowed, so B can be back-to-back.
  - Only one write is in flight, so a second AW stalls (AWREADY = 0) until the commit.
- Hazards:
  - A read sampled in the same cycle as a write commit to the same word returns the pre-write data.
  - Any read accepted after the commit cycle returns the new data.
- IDs are echoed unchanged. ID reuse among outstanding requests is legal, because ordering is preserved.

Test Plan:
- Write then read: AW addr 0x10, id 3 and W 0xDEADBEEF, strb 0xF in the same cycle → BVALID two cycles later with BID = 3, BRESP = 0. A following AR 0x10, id 5 → the next cycle has RVALID, RID = 5, RDATA = 0xDEADBEEF, RLAST = 1.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with strb 0x5 → read 0x20 returns 0x11BB33DD.
- Outstanding reads and backpressure: hold RREADY = 0 and issue AR ids 0..5 on consecutive cycles → 4 accepted, then ARREADY = 0. Raise RREADY → RID order is 0, 1, 2, 3 and ARREADY returns the cycle after the first pop.
- Decode error: AR at BASE_ADDR + 4*DEPTH_WORDS → RRESP = 2'b11, RDATA = 0. A write to the same address → BRESP = 2'b11, and memory is unchanged when checked by a read of all words written earlier.
- Ordering and B backpressure: W arrives 3 cycles before AW while BREADY = 0 and a B is pending → WREADY and AWREADY drop after their handshakes, and the commit waits for BREADY. B fields stay stable throughout.
- Reset mid-flight: 3 reads queued and a held AW, then reset pulsed low → all ready and valid outputs are 0 during reset. After release, ARREADY = AWREADY = WREADY = 1 and no stale R or B appears. Pre-reset memory data is still readable.

Source files
------------

// File: rtl/riscv_axi_sram_subordinate.sv
// riscv_axi_sram_subordinate: single-beat AXI4 subordinate backed by a word-addressed SRAM.
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   AXI_AW_M/AXI_AW_S  write address channel (valid/id/addr in, ready out)
//   AXI_W_M/AXI_W_S    write data channel (valid/data/strb in, ready out)
//   AXI_B_M/AXI_B_S    write response channel (ready in, valid/id/resp out)
//   AXI_AR_M/AXI_AR_S  read address channel (valid/id/addr in, ready out)
//   AXI_R_M/AXI_R_S    read data channel (ready in, valid/id/data/resp/last out)
package axi4_pkg;
   typedef struct packed {logic valid; logic [3:0] id; logic [31:0] addr;} aw_m;
   typedef struct packed {logic valid; logic [31:0] data; logic [3:0] strb;} w_m;
   typedef struct packed {logic ready;} b_m;
   typedef struct packed {logic valid; logic [3:0] id; logic [31:0] addr;} ar_m;
   typedef struct packed {logic ready;} r_m;
   typedef struct packed {logic ready;} aw_s;
   typedef struct packed {logic ready;} w_s;
   typedef struct packed {logic valid; logic [3:0] id; logic [1:0] resp;} b_s;
   typedef struct packed {logic ready;} ar_s;
   typedef struct packed {logic valid; logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_s;
endpackage

module riscv_axi_sram_subordinate #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_Q_DEPTH  = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  axi4_pkg::aw_m   AXI_AW_M,
   input  axi4_pkg::w_m    AXI_W_M,
   input  axi4_pkg::b_m    AXI_B_M,
   input  axi4_pkg::ar_m   AXI_AR_M,
   input  axi4_pkg::r_m    AXI_R_M,
   output axi4_pkg::aw_s   AXI_AW_S,
   output axi4_pkg::w_s    AXI_W_S,
   output axi4_pkg::b_s    AXI_B_S,
   output axi4_pkg::ar_s   AXI_AR_S,
   output axi4_pkg::r_s    AXI_R_S
);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(RD_Q_DEPTH);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [3:0]    r_q_id [RD_Q_DEPTH];
   logic [31:0]   r_q_data [RD_Q_DEPTH];
   logic [1:0]    r_q_resp [RD_Q_DEPTH];
   logic [PW:0]   r_wp, r_rp;
   logic          r_live;
   logic          r_aw_held, r_aw_ok, r_w_held;
   logic [3:0]    r_aw_id;
   logic [IW-1:0] r_aw_idx;
   logic [31:0]   r_w_data;
   logic [3:0]    r_w_strb;
   logic          r_b_valid;
   logic [3:0]    r_b_id;
   logic [1:0]    r_b_resp;

   // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both bounds.
   logic [31:0]   w_ar_off, w_aw_off;
   logic          w_ar_ok, w_aw_ok;
   logic          w_empty, w_full, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_commit;
   logic [PW-1:0] w_head;

   assign w_ar_off = AXI_AR_M.addr - BASE_ADDR;
   assign w_aw_off = AXI_AW_M.addr - BASE_ADDR;
   assign w_ar_ok  = {1'b0, w_ar_off} < SPAN;
   assign w_aw_ok  = {1'b0, w_aw_off} < SPAN;
   assign w_empty  = r_wp == r_rp;
   assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
   assign w_head   = r_rp[PW-1:0];
   assign w_ar_hs  = AXI_AR_M.valid & ~w_full & r_live;
   assign w_r_hs   = ~w_empty & AXI_R_M.ready;
   assign w_aw_hs  = AXI_AW_M.valid & ~r_aw_held & r_live;
   assign w_w_hs   = AXI_W_M.valid & ~r_w_held & r_live;
   assign w_commit = r_aw_held & r_w_held & (~r_b_valid | AXI_B_M.ready);

   // r_live keeps every ready low while reset is asserted without a reset-to-output path.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_live    <= 1'b0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_aw_held <= 1'b0;
         r_aw_ok   <= 1'b0;
         r_aw_id   <= '0;
         r_aw_idx  <= '0;
         r_w_held  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_b_valid <= 1'b0;
         r_b_id    <= '0;
         r_b_resp  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_ar_hs) r_wp <= r_wp + 1'b1;
         if (w_r_hs) r_rp <= r_rp + 1'b1;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_ok   <= w_aw_ok;
            r_aw_id   <= AXI_AW_M.id;
            r_aw_idx  <= w_aw_off[IW+1:2];
         end else if (w_commit) r_aw_held <= 1'b0;
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= AXI_W_M.data;
            r_w_strb <= AXI_W_M.strb;
         end else if (w_commit) r_w_held <= 1'b0;
         if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_id    <= r_aw_id;
            r_b_resp  <= r_aw_ok ? 2'b00 : 2'b11;
         end else if (AXI_B_M.ready) r_b_valid <= 1'b0;
      end
   end

   // Storage is not reset; a read and a commit to the same word in one cycle sees the old word.
   always_ff @(posedge clock) begin
      if (w_ar_hs) begin
         r_q_id[r_wp[PW-1:0]]   <= AXI_AR_M.id;
         r_q_data[r_wp[PW-1:0]] <= w_ar_ok ? r_mem[w_ar_off[IW+1:2]] : 32'h0;
         r_q_resp[r_wp[PW-1:0]] <= w_ar_ok ? 2'b00 : 2'b11;
      end
      if (w_commit && r_aw_ok)
         for (int i = 0; i < 4; i++)
            if (r_w_strb[i]) r_mem[r_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
   end

   assign AXI_AW_S.ready = ~r_aw_held & r_live;
   assign AXI_W_S.ready  = ~r_w_held & r_live;
   assign AXI_AR_S.ready = ~w_full & r_live;
   assign AXI_B_S.valid  = r_b_valid;
   assign AXI_B_S.id     = r_b_id;
   assign AXI_B_S.resp   = r_b_resp;
   assign AXI_R_S.valid  = ~w_empty;
   assign AXI_R_S.id     = w_empty ? 4'h0 : r_q_id[w_head];
   assign AXI_R_S.data   = w_empty ? 32'h0 : r_q_data[w_head];
   assign AXI_R_S.resp   = w_empty ? 2'b00 : r_q_resp[w_head];
   assign AXI_R_S.last   = ~w_empty;
endmodule
